// File: rtl/cpu86_retire_trace_checker.sv
// Retire-trace checker: buffers DUT retires, aligns them to a golden trace
// by CS:IP, compares masked registers and tracks errors until a halt limit.
module cpu86_retire_trace_checker #(
    parameter int              NREGS      = 13,
    parameter int              REG_W      = 16,
    parameter int              FIFO_DEPTH = 8,
    parameter logic [REG_W-1:0] FL_MASK   = 16'h0FD5,
    parameter int              MAX_SKIP   = 4,
    parameter int              MAX_ERRORS = 100,
    parameter int              ERR_W      = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   dut_valid,
    input  logic [31:0]            dut_csip,
    input  logic [NREGS*REG_W-1:0] dut_regs,
    input  logic [NREGS-1:0]       dut_mask,
    input  logic                   exp_valid,
    output logic                   exp_ready,
    input  logic [31:0]            exp_csip,
    input  logic [NREGS*REG_W-1:0] exp_regs,
    output logic                   cmp_valid,
    output logic [NREGS-1:0]       cmp_mismatch,
    output logic                   desync,
    output logic                   ovf,
    output logic                   halted,
    output logic [ERR_W-1:0]       err_cnt,
    output logic [31:0]            first_err_csip,
    output logic [NREGS:0]         first_err_vec
);

    localparam int RW     = NREGS * REG_W;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int SW     = $clog2(MAX_SKIP + 2);
    localparam int FL_IDX = 12;

    localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0]    SKIP_LIM = SW'(MAX_SKIP);
    localparam logic [ERR_W-1:0] ERR_LIM  = ERR_W'(MAX_ERRORS);
    localparam logic [ERR_W-1:0] ERR_SAT  = '1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    logic [31:0]      mem_csip_q [FIFO_DEPTH];
    logic [RW-1:0]    mem_regs_q [FIFO_DEPTH];
    logic [NREGS-1:0] mem_mask_q [FIFO_DEPTH];

    state_e           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [SW-1:0]    skip_cnt_q, skip_cnt_d;
    logic             cmp_valid_q, cmp_valid_d;
    logic [NREGS-1:0] cmp_mismatch_q, cmp_mismatch_d;
    logic             desync_q, desync_d;
    logic             ovf_q, ovf_d;
    logic             halted_q, halted_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]      first_err_csip_q, first_err_csip_d;
    logic [NREGS:0]   first_err_vec_q, first_err_vec_d;

    logic             full;
    logic             act;
    logic             csip_hit;
    logic             do_match;
    logic             do_squash;
    logic             do_desync;
    logic             push;
    logic             pop;
    logic             err;
    logic [31:0]      head_csip;
    logic [RW-1:0]    head_regs;
    logic [NREGS-1:0] head_mask;
    logic [NREGS-1:0] cmp_vec;
    logic [REG_W-1:0] diff;

    always_comb begin
        head_csip = mem_csip_q[rd_ptr_q];
        head_regs = mem_regs_q[rd_ptr_q];
        head_mask = mem_mask_q[rd_ptr_q];
        full      = (count_q == DEPTH_C);
        act       = (state_q == RUN) && (count_q != '0) && exp_valid;
        csip_hit  = (head_csip == exp_csip);
        do_match  = act && csip_hit;
        do_squash = act && !csip_hit && (skip_cnt_q < SKIP_LIM);
        do_desync = act && !csip_hit && (skip_cnt_q >= SKIP_LIM);
        pop       = act;
        push      = dut_valid && (!full || pop);
    end

    assign exp_ready = do_match || do_desync;

    // FL is compared only on its architecturally meaningful flag bits
    always_comb begin
        cmp_vec = '0;
        diff    = '0;
        for (int i = 0; i < NREGS; i++) begin
            diff = head_regs[i*REG_W +: REG_W] ^ exp_regs[i*REG_W +: REG_W];
            if (i == FL_IDX) begin
                diff = diff & FL_MASK;
            end
            cmp_vec[i] = head_mask[i] && (diff != '0);
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        ovf_d = ovf_q || (dut_valid && full && !pop);

        skip_cnt_d = skip_cnt_q;
        if (do_match || do_desync) begin
            skip_cnt_d = '0;
        end else if (do_squash) begin
            skip_cnt_d = skip_cnt_q + 1'b1;
        end

        cmp_valid_d    = do_match;
        cmp_mismatch_d = do_match ? cmp_vec : '0;
        desync_d       = do_desync;

        err       = (do_match && (cmp_vec != '0)) || do_desync;
        err_cnt_d = err_cnt_q;
        if (err && (err_cnt_q != ERR_SAT)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        first_err_csip_d = first_err_csip_q;
        first_err_vec_d  = first_err_vec_q;
        if (err && (err_cnt_q == '0)) begin
            first_err_csip_d = do_desync ? exp_csip : head_csip;
            first_err_vec_d  = do_desync ? {1'b1, {NREGS{1'b0}}}
                                         : {1'b0, cmp_vec};
        end

        state_d = state_q;
        if ((state_q == RUN) && err && (err_cnt_d == ERR_LIM)) begin
            state_d = HALT;
        end
        halted_d = (state_d == HALT);
    end

    // Storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_csip_q[wr_ptr_q] <= dut_csip;
            mem_regs_q[wr_ptr_q] <= dut_regs;
            mem_mask_q[wr_ptr_q] <= dut_mask;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= RUN;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            skip_cnt_q       <= '0;
            cmp_valid_q      <= 1'b0;
            cmp_mismatch_q   <= '0;
            desync_q         <= 1'b0;
            ovf_q            <= 1'b0;
            halted_q         <= 1'b0;
            err_cnt_q        <= '0;
            first_err_csip_q <= '0;
            first_err_vec_q  <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            skip_cnt_q       <= skip_cnt_d;
            cmp_valid_q      <= cmp_valid_d;
            cmp_mismatch_q   <= cmp_mismatch_d;
            desync_q         <= desync_d;
            ovf_q            <= ovf_d;
            halted_q         <= halted_d;
            err_cnt_q        <= err_cnt_d;
            first_err_csip_q <= first_err_csip_d;
            first_err_vec_q  <= first_err_vec_d;
        end
    end

    assign cmp_valid      = cmp_valid_q;
    assign cmp_mismatch   = cmp_mismatch_q;
    assign desync         = desync_q;
    assign ovf            = ovf_q;
    assign halted         = halted_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_csip = first_err_csip_q;
    assign first_err_vec  = first_err_vec_q;

endmodule

// File: tb/tb_cpu86_retire_trace_checker.sv
// Scoreboard bench for cpu86_retire_trace_checker: golden records and
// expected compare events are queued at stimulus time, popped on DUT output.
module tb_cpu86_retire_trace_checker;

    localparam int NREGS = 13;
    localparam int REG_W = 16;
    localparam int RW    = NREGS * REG_W;
    localparam int ERR_W = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             dut_valid = 1'b0;
    logic [31:0]      dut_csip = '0;
    logic [RW-1:0]    dut_regs = '0;
    logic [NREGS-1:0] dut_mask = '0;
    logic             exp_valid;
    logic             exp_ready;
    logic [31:0]      exp_csip;
    logic [RW-1:0]    exp_regs;
    logic             cmp_valid;
    logic [NREGS-1:0] cmp_mismatch;
    logic             desync;
    logic             ovf;
    logic             halted;
    logic [ERR_W-1:0] err_cnt;
    logic [31:0]      first_err_csip;
    logic [NREGS:0]   first_err_vec;

    cpu86_retire_trace_checker #(
        .NREGS(NREGS), .REG_W(REG_W), .FIFO_DEPTH(8), .FL_MASK(16'h0FD5),
        .MAX_SKIP(4), .MAX_ERRORS(100), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .dut_valid(dut_valid), .dut_csip(dut_csip),
        .dut_regs(dut_regs), .dut_mask(dut_mask),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_csip(exp_csip), .exp_regs(exp_regs),
        .cmp_valid(cmp_valid), .cmp_mismatch(cmp_mismatch),
        .desync(desync), .ovf(ovf), .halted(halted),
        .err_cnt(err_cnt), .first_err_csip(first_err_csip),
        .first_err_vec(first_err_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   csip;
        logic [RW-1:0] regs;
    } exp_rec_t;

    typedef struct {
        logic             dsync;
        logic [NREGS-1:0] vec;
    } ev_t;

    exp_rec_t      exp_q[$];
    ev_t           ev_q[$];
    ev_t           ev;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            took = 1'b0;
    logic [RW-1:0] r, d;
    logic [RW-1:0] keep [9];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [RW-1:0] rand_regs();
        logic [RW-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            v[i*REG_W +: REG_W] = 16'($urandom);
        end
        return v;
    endfunction

    // Golden-stream driver: head of exp_q is presented until consumed
    initial begin
        exp_valid = 1'b0;
        exp_csip  = '0;
        exp_regs  = '0;
        forever begin
            @(negedge clk);
            if (took && exp_q.size() > 0) begin
                exp_q.delete(0);
            end
            if (exp_q.size() > 0) begin
                exp_valid = 1'b1;
                exp_csip  = exp_q[0].csip;
                exp_regs  = exp_q[0].regs;
            end else begin
                exp_valid = 1'b0;
            end
            #4;
            took = exp_valid && exp_ready;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resetn && (cmp_valid || desync)) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_event", 64'({cmp_valid, desync}), 64'd0);
                end else begin
                    ev = ev_q.pop_front();
                    chk("evt_desync", 64'(desync), 64'(ev.dsync));
                    chk("evt_cmp_valid", 64'(cmp_valid), 64'(!ev.dsync));
                    chk("evt_vec", 64'(cmp_mismatch),
                        ev.dsync ? 64'd0 : 64'(ev.vec));
                    if (ev.dsync) begin
                        chk("desync_exp_ready", 64'(took), 64'd1);
                    end
                end
            end
        end
    end

    task automatic retire(input logic [31:0] c, input logic [RW-1:0] v,
                          input logic [NREGS-1:0] m);
        @(negedge clk);
        dut_valid = 1'b1;
        dut_csip  = c;
        dut_regs  = v;
        dut_mask  = m;
    endtask

    task automatic idle();
        @(negedge clk);
        dut_valid = 1'b0;
    endtask

    task automatic expect_rec(input logic [31:0] c, input logic [RW-1:0] v);
        exp_q.push_back('{csip: c, regs: v});
    endtask

    task automatic expect_ev(input logic ds, input logic [NREGS-1:0] v);
        ev_q.push_back('{dsync: ds, vec: v});
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && ev_q.size() > 0; i++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("drain_pending", 64'(ev_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        resetn    = 1'b0;
        dut_valid = 1'b0;
        exp_q.delete();
        ev_q.delete();
        #1;
        chk("rst_cmp_valid", 64'(cmp_valid), 64'd0);
        chk("rst_cmp_mismatch", 64'(cmp_mismatch), 64'd0);
        chk("rst_desync", 64'(desync), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_first_csip", 64'(first_err_csip), 64'd0);
        chk("rst_first_vec", 64'(first_err_vec), 64'd0);
        chk("rst_exp_ready", 64'(exp_ready), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        took   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        for (int k = 0; k < 3; k++) begin
            r = rand_regs();
            expect_rec(32'h100 + 32'(2 * k), r);
            expect_ev(1'b0, '0);
            retire(32'h100 + 32'(2 * k), r, 13'h1FFF);
        end
        idle();
        drain();
        chk("clean_err_cnt", 64'(err_cnt), 64'd0);

        r = rand_regs();
        r[15:0] = 16'h1234;
        d = r;
        d[15:0] = 16'h1235;
        expect_rec(32'h100, r);
        expect_ev(1'b0, 13'h0001);
        retire(32'h100, d, 13'h1FFF);
        idle();
        drain();
        chk("ax_err_cnt", 64'(err_cnt), 64'd1);
        chk("ax_first_csip", 64'(first_err_csip), 64'h100);
        chk("ax_first_vec", 64'(first_err_vec), 64'h0001);

        expect_rec(32'h110, r);
        expect_ev(1'b0, '0);
        retire(32'h110, d, 13'h1FFE);
        idle();
        drain();
        chk("ax_masked_err_cnt", 64'(err_cnt), 64'd1);

        r = rand_regs();
        d = r;
        d[12*REG_W +: REG_W] = d[12*REG_W +: REG_W] ^ 16'h0002;
        expect_rec(32'h120, r);
        expect_ev(1'b0, '0);
        retire(32'h120, d, 13'h1FFF);
        d = r;
        d[12*REG_W +: REG_W] = d[12*REG_W +: REG_W] ^ 16'h0040;
        expect_rec(32'h122, r);
        expect_ev(1'b0, 13'h1000);
        retire(32'h122, d, 13'h1FFF);
        idle();
        drain();
        chk("fl_err_cnt", 64'(err_cnt), 64'd2);
        chk("fl_first_vec_kept", 64'(first_err_vec), 64'h0001);

        r = rand_regs();
        expect_rec(32'h300, r);
        expect_ev(1'b0, '0);
        retire(32'h200, rand_regs(), 13'h1FFF);
        retire(32'h202, rand_regs(), 13'h1FFF);
        retire(32'h300, r, 13'h1FFF);
        idle();
        drain();
        chk("squash_err_cnt", 64'(err_cnt), 64'd2);

        do_reset();
        r = rand_regs();
        expect_rec(32'h500, r);
        expect_ev(1'b1, '0);
        for (int k = 0; k < 5; k++) begin
            retire(32'h400 + 32'(2 * k), rand_regs(), 13'h1FFF);
        end
        idle();
        drain();
        chk("desync_err_cnt", 64'(err_cnt), 64'd1);
        chk("desync_first_vec", 64'(first_err_vec), 64'h2000);
        chk("desync_first_csip", 64'(first_err_csip), 64'h500);
        chk("desync_exp_consumed", 64'(exp_q.size()), 64'd0);

        do_reset();
        for (int k = 0; k < 9; k++) begin
            keep[k] = rand_regs();
            retire(32'h600 + 32'(2 * k), keep[k], 13'h1FFF);
        end
        idle();
        repeat (2) @(negedge clk);
        chk("ovf_set", 64'(ovf), 64'd1);
        for (int k = 0; k < 9; k++) begin
            expect_rec(32'h600 + 32'(2 * k), keep[k]);
        end
        for (int k = 0; k < 8; k++) begin
            expect_ev(1'b0, '0);
        end
        drain();
        chk("ovf_kept_eight", 64'(exp_q.size()), 64'd1);
        chk("ovf_err_cnt", 64'(err_cnt), 64'd0);

        do_reset();
        for (int k = 0; k < 100; k++) begin
            r = rand_regs();
            r[15:0] = 16'h00AA;
            d = r;
            d[15:0] = 16'h00AB;
            expect_rec(32'h1000 + 32'(2 * k), r);
            expect_ev(1'b0, 13'h0001);
            retire(32'h1000 + 32'(2 * k), d, 13'h0001);
        end
        idle();
        drain();
        chk("halt_set", 64'(halted), 64'd1);
        chk("halt_err_cnt", 64'(err_cnt), 64'd100);
        chk("halt_no_ovf_yet", 64'(ovf), 64'd0);

        r = rand_regs();
        expect_rec(32'h9000, r);
        retire(32'h9000, r, 13'h1FFF);
        for (int k = 0; k < 9; k++) begin
            retire(32'h9100 + 32'(2 * k), rand_regs(), 13'h1FFF);
            #1;
            chk("halt_exp_ready", 64'(exp_ready), 64'd0);
        end
        idle();
        repeat (3) @(negedge clk);
        chk("halt_ovf", 64'(ovf), 64'd1);
        chk("halt_exp_held", 64'(exp_q.size()), 64'd1);
        chk("halt_sticky", 64'(halted), 64'd1);

        do_reset();
        repeat (2) @(negedge clk);
        chk("post_rst_halted", 64'(halted), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu86_retire_trace_checker.md
Name: cpu86_retire_trace_checker

Overview:
- Synthesizable, parametrised successor to the cpu86 exec-stage register-reader checker.
- Buffers DUT retire records (CS:IP plus register file snapshot) in a FIFO and pairs each one with an expected-trace record from a golden stream.
- Records whose CS:IP does not match the expected head are squashed retires (mispredicted branches) and are skipped.
- Matched pairs are compared per register under a per-record check mask. Error counting, first-error capture and halt-on-limit are provided for sim and FPGA builds.

Parameters:
- NREGS, 13, number of architectural registers. Index map: 0 AX, 1 DX, 2 CX, 3 BX, 4 BP, 5 SI, 6 DI, 7 SP, 8 ES, 9 CS, 10 SS, 11 DS, 12 FL.
- REG_W, 16, register width.
- FIFO_DEPTH, 8, DUT record FIFO depth; power of 2, at least 2.
- FL_MASK, 16'h0FD5, FL bits compared (CF, PF, AF, ZF, SF, TF, IF, DF, OF).
- MAX_SKIP, 4, consecutive squashed retires tolerated before desync.
- MAX_ERRORS, 100, error count at which the checker halts.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous active-low
- dut_valid  in  1  retire strobe; no backpressure
- dut_csip  in  32  {CS, IP} of the retired instruction
- dut_regs  in  NREGS*REG_W  register snapshot; reg i at [i*REG_W +: REG_W]
- dut_mask  in  NREGS  registers to check for this instruction, from the upstream op/dir/code decode
- exp_valid  in  1  expected record valid
- exp_ready  out  1  expected record consumed
- exp_csip  in  32  expected {CS, IP}
- exp_regs  in  NREGS*REG_W  expected registers
- cmp_valid  out  1  one-cycle pulse per compared pair
- cmp_mismatch  out  NREGS  per-register mismatch of the last compare
- desync  out  1  one-cycle pulse on skip-limit error
- ovf  out  1  sticky; a DUT record was dropped
- halted  out  1  sticky; err_cnt reached MAX_ERRORS
- err_cnt  out  ERR_W  saturating error count
- first_err_csip  out  32  CS:IP of the first error
- first_err_vec  out  NREGS+1  mismatch vector of the first error; bit NREGS marks desync

Behaviour:
- Reset (async assert, synchronous deassert use): every output is 0, FIFO is empty, skip_cnt is 0, state is RUN.
- Push: a record {csip, regs, mask} is pushed when dut_valid=1.
  - Full with no pop in the same cycle: the record is dropped and ovf is set.
  - Full with a pop in the same cycle: push and pop both succeed.
  - The FIFO is write-then-read: a record pushed in cycle N is eligible at the head in cycle N+1.
- State RUN, head present (FIFO non-empty) and exp_valid=1:
  - CS:IP match (head csip == exp_csip): pop the head, exp_ready=1, skip_cnt cleared, compare issued.
  - CS:IP mismatch with skip_cnt < MAX_SKIP: pop the head only (squash), exp_ready=0, skip_cnt increments.
  - CS:IP mismatch with skip_cnt == MAX_SKIP: pop the head, exp_ready=1 (realign), skip_cnt cleared, desync error issued.
- exp_ready is combinational and is 0 outside the match and desync cases above.
- Compare of register i:
  - mismatch[i] = mask[i] & (dut_reg[i] != exp_reg[i]).
  - For i = 12 (FL) the compare is done under FL_MASK.
  - Segment registers are compared only when their mask bit is set.
- Outputs are registered with a latency of 1 cycle from the pop:
  - cmp_valid=1 and cmp_mismatch = the compare vector.
  - On desync: desync=1, cmp_valid=0, cmp_mismatch=0.
- Error: a compare with a non-zero vector, or a desync, counts as one error.
  - err_cnt increments and saturates at 2^ERR_W-1.
  - On the first error only, first_err_csip/first_err_vec capture the CS:IP and vector. For a desync, the captured CS:IP is exp_csip.
- HALT: entered on the cycle err_cnt becomes MAX_ERRORS.
  - No pops and no exp_ready.
  - Pushes continue, so ovf may set.
  - Left only by reset.
- Mid-operation reset clears the FIFO, the state and all sticky outputs immediately.

Test Plan:
- Three retires at CS:IP 0000:0100, 0102, 0104 with matching expected records, mask 0x1FFF -> cmp_valid three times, cmp_mismatch=0, err_cnt=0.
- Expected AX=0x1234, DUT AX=0x1235: with mask bit0=1 -> cmp_mismatch=0x0001, err_cnt=1, first_err_csip=0x00000100. With mask bit0=0 -> no error.
- FL differs only in bit 1 (outside FL_MASK) -> no mismatch. FL differs in bit 6 (ZF) -> cmp_mismatch bit12=1.
- Two squashed retires at 0000:0200 and 0000:0202 before the expected 0000:0300 -> both skipped, 0000:0300 compared clean, desync never pulses.
- Five consecutive non-matching retires with MAX_SKIP=4 -> desync pulse on the 5th, exp_ready=1 that cycle, first_err_vec bit13=1.
- Hold exp_valid=0 and push FIFO_DEPTH+1 retires -> ovf=1, exactly 8 records kept.
- Force 100 mismatches -> halted=1, exp_ready stays 0.
- Assert resetn=0 mid-stream -> all outputs 0 immediately.
